multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control FSM for the 32-bit multi-cycle RISC-V (RV32I) datapath. It sequences the write enables of the datapath's architectural and temporary 32-bit registers (PC, IR/OLD_PC, MDR, A, B, ALUOut), drives the operand/writeback/PC-source muxes, and owns the single shared memory port through a req/ready handshake. One instruction completes every 3–5 states, plus any memory wait cycles.

## Interface
Parameters:
- `RESET_STATE`, 3'd0: state entered on reset (FETCH); not intended to be overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  IR[6:0].
- `branch_taken`  in  1  datapath comparator result for IR's funct3, valid in EXEC.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  write request (store).
- `addr_sel`  out  1  0 = PC, 1 = ALUOut.
- `pc_en`, `ir_en`, `mdr_en`, `ab_en`, `aluout_en`, `rf_we`  out  1 each  register enables; `ir_en` also loads OLD_PC.
- `alu_a_sel`  out  2  0 = PC, 1 = A, 2 = zero, 3 = OLD_PC.
- `alu_b_sel`  out  2  0 = B, 1 = imm, 2 = const 4.
- `alu_op_add`  out  1  1 forces ADD; 0 = ALU decodes funct3/funct7.
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = ALU result with bit 0 cleared (JALR).
- `wb_sel`  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- States (3-bit binary encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- All outputs are combinational from state, opcode, mem_ready, and branch_taken. Unlisted outputs are 0.
- FETCH: `mem_req`=1, `addr_sel`=0, `alu_a_sel`=0, `alu_b_sel`=2, `alu_op_add`=1, `pc_src`=0.
  - On `mem_ready`: `ir_en`=1 and `pc_en`=1 (PC←PC+4), then go to DECODE.
  - Otherwise remain in FETCH.
- DECODE: `ab_en`=1; `aluout_en`=1 with `alu_a_sel`=3, `alu_b_sel`=1, `alu_op_add`=1 (ALUOut←OLD_PC+imm). Always go to EXEC.
- EXEC, by opcode:
  - R-type 0110011: a=1, b=0, `aluout_en`; go to WB.
  - I-ALU 0010011: a=1, b=1, `aluout_en`; go to WB.
  - LOAD 0000011 / STORE 0100011: a=1, b=1, add, `aluout_en`; go to MEM.
  - LUI 0110111: a=2, b=1, add, `aluout_en`; go to WB.
  - AUIPC 0010111: a=3, b=1, add, `aluout_en`; go to WB.
  - BRANCH 1100011: a=1, b=0; `pc_src`=1; `pc_en`=`branch_taken`; `retire`; go to FETCH.
  - JAL 1101111: `pc_src`=1, `pc_en`, `rf_we`, `wb_sel`=2 (rd←PC+4, since PC updates on the same edge); `retire`; go to FETCH.
  - JALR 1100111: a=1, b=1, add, `pc_src`=2, `pc_en`, `rf_we`, `wb_sel`=2; `retire`; go to FETCH.
  - Any other opcode: go to TRAP if `ILLEGAL_TRAP_EN` is defined, else go to FETCH with `retire` (executes as NOP).
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=(opcode==STORE).
  - On `mem_ready` for a load: `mdr_en`, go to WB.
  - On `mem_ready` for a store: `retire`, go to FETCH.
- WB: `rf_we`=1, `wb_sel`=1 for LOAD else 0; `retire`; go to FETCH.
- TRAP: all enables and `mem_req` are 0; `illegal`=1; the FSM stays in TRAP until reset.

## Timing
- Reset: state←FETCH asynchronously, `illegal`←0. While `rst`=1, every output is forced to 0, including `mem_req`. The first `mem_req` is driven in the cycle after `rst` deasserts.
- Reset mid-request drops `mem_req` immediately. The memory must tolerate an abort.
- `mem_req`, `mem_we`, and `addr_sel` stay stable from assertion until the cycle `mem_ready`=1, inclusive.
- `mem_ready` outside FETCH/MEM is ignored.
- Latency with zero-wait memory (`mem_ready` high in the first request cycle):
  - ALU / LUI / AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH / JAL / JALR: 3 cycles.
- Each memory wait cycle adds one cycle.
- `retire` asserts exactly once per instruction, in its final cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined: an unknown opcode in EXEC enters TRAP. `illegal` goes high on the next edge and stays high until `rst`. No further `mem_req` or `retire` is issued.
- Not defined: the TRAP state and sticky flag are not built, and `illegal` is tied to 0. An unknown opcode retires as a NOP, with PC already advanced by 4.

## Test plan
- Reset: assert `rst` asynchronously mid-FETCH with `mem_req`=1 → all outputs 0 within the same cycle; after release, `mem_req`=1 with `addr_sel`=0 on the next cycle.
- ADD (opcode 0110011), zero-wait memory → `ir_en`/`pc_en` in cycle 1, `ab_en` in cycle 2, `aluout_en` in cycle 3, `rf_we`/`wb_sel`=0/`retire` in cycle 4.
- LW with `mem_ready` delayed 3 cycles in MEM → `mem_req`/`addr_sel`=1 held for 4 cycles, `mdr_en` only on the ready cycle, then WB with `wb_sel`=1; total 8 cycles.
- SW with `mem_ready`=1 → `mem_we`=1 in MEM, `retire` in that cycle, no `rf_we`; FETCH follows.
- BEQ twice, with `branch_taken`=1 then 0 → `pc_en`=1 with `pc_src`=1 the first time and `pc_en`=0 the second; both retire in cycle 3.
- Opcode 7'h7F: with the macro → TRAP, `illegal`=1 sticky, `mem_req` stays 0 for 20 cycles. Without the macro → `retire` in EXEC, and FETCH resumes next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I datapath: register enables, mux selects and the shared memory port.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state instead of retiring as NOPs.
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       pc_en,
  output logic       ir_en,
  output logic       mdr_en,
  output logic       ab_en,
  output logic       aluout_en,
  output logic       rf_we,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       alu_op_add,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [2:0] state_r;
  logic [2:0] next_state_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= next_state_s;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (next_state_s == TRAP) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  // Next-state and output decode; everything is held at 0 while rst is high
  always_comb begin
    next_state_s = state_r;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    pc_en        = 1'b0;
    ir_en        = 1'b0;
    mdr_en       = 1'b0;
    ab_en        = 1'b0;
    aluout_en    = 1'b0;
    rf_we        = 1'b0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 2'd0;
    alu_op_add   = 1'b0;
    pc_src       = 2'd0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    if (rst) begin
      next_state_s = RESET_STATE;
    end else begin
      case (state_r)
        FETCH: begin
          mem_req    = 1'b1;
          alu_b_sel  = 2'd2;
          alu_op_add = 1'b1;
          if (mem_ready) begin
            ir_en        = 1'b1;
            pc_en        = 1'b1;
            next_state_s = DECODE;
          end else begin
            next_state_s = FETCH;
          end
        end
        DECODE: begin
          ab_en        = 1'b1;
          aluout_en    = 1'b1;
          alu_a_sel    = 2'd3;
          alu_b_sel    = 2'd1;
          alu_op_add   = 1'b1;
          next_state_s = EXEC;
        end
        EXEC: begin
          case (opcode)
            OP_R: begin
              alu_a_sel    = 2'd1;
              aluout_en    = 1'b1;
              next_state_s = WB;
            end
            OP_I: begin
              alu_a_sel    = 2'd1;
              alu_b_sel    = 2'd1;
              aluout_en    = 1'b1;
              next_state_s = WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_a_sel    = 2'd1;
              alu_b_sel    = 2'd1;
              alu_op_add   = 1'b1;
              aluout_en    = 1'b1;
              next_state_s = MEM;
            end
            OP_LUI: begin
              alu_a_sel    = 2'd2;
              alu_b_sel    = 2'd1;
              alu_op_add   = 1'b1;
              aluout_en    = 1'b1;
              next_state_s = WB;
            end
            OP_AUIPC: begin
              alu_a_sel    = 2'd3;
              alu_b_sel    = 2'd1;
              alu_op_add   = 1'b1;
              aluout_en    = 1'b1;
              next_state_s = WB;
            end
            OP_BRANCH: begin
              alu_a_sel    = 2'd1;
              pc_src       = 2'd1;
              pc_en        = branch_taken;
              retire       = 1'b1;
              next_state_s = FETCH;
            end
            OP_JAL: begin
              // PC and rd update on the same edge, so rd takes the already-advanced PC
              pc_src       = 2'd1;
              pc_en        = 1'b1;
              rf_we        = 1'b1;
              wb_sel       = 2'd2;
              retire       = 1'b1;
              next_state_s = FETCH;
            end
            OP_JALR: begin
              alu_a_sel    = 2'd1;
              alu_b_sel    = 2'd1;
              alu_op_add   = 1'b1;
              pc_src       = 2'd2;
              pc_en        = 1'b1;
              rf_we        = 1'b1;
              wb_sel       = 2'd2;
              retire       = 1'b1;
              next_state_s = FETCH;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
              next_state_s = TRAP;
`else
              retire       = 1'b1;
              next_state_s = FETCH;
`endif
            end
          endcase
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_LOAD) begin
              mdr_en       = 1'b1;
              next_state_s = WB;
            end else begin
              retire       = 1'b1;
              next_state_s = FETCH;
            end
          end else begin
            next_state_s = MEM;
          end
        end
        WB: begin
          rf_we        = 1'b1;
          wb_sel       = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
          retire       = 1'b1;
          next_state_s = FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          next_state_s = TRAP;
        end
`endif
        default: begin
          next_state_s = RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle schedules built from the opcode class,
// randomized memory wait states, branch outcomes and spurious mem_ready outside memory phases.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_sel, pc_en, ir_en, mdr_en, ab_en, aluout_en, rf_we;
  logic [1:0] alu_a_sel, alu_b_sel, pc_src, wb_sel;
  logic       alu_op_add, retire, illegal;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       pc_en;
    logic       ir_en;
    logic       mdr_en;
    logic       ab_en;
    logic       aluout_en;
    logic       rf_we;
    logic [1:0] a;
    logic [1:0] b;
    logic       add;
    logic [1:0] pc_src;
    logic [1:0] wb;
    logic       retire;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic  rdy;
    outs_t exp;
    string tag;
  } ent_t;

  outs_t obs;
  ent_t  sched[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    n_retire_exp = 0;
  int    n_retire_obs = 0;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                                7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};

  assign obs = {mem_req, mem_we, addr_sel, pc_en, ir_en, mdr_en, ab_en, aluout_en, rf_we,
                alu_a_sel, alu_b_sel, alu_op_add, pc_src, wb_sel, retire, illegal};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .pc_en(pc_en), .ir_en(ir_en),
    .mdr_en(mdr_en), .ab_en(ab_en), .aluout_en(aluout_en), .rf_we(rf_we),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op_add(alu_op_add), .pc_src(pc_src),
    .wb_sel(wb_sel), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic rdy, input outs_t o, input string tag);
    ent_t e;
    e.rdy = rdy;
    e.exp = o;
    e.tag = tag;
    return e;
  endfunction

  // Entered #1 after a rising edge; each entry spans one clock cycle.
  task automatic run_sched();
    ent_t e;
    while (sched.size() > 0) begin
      e = sched.pop_front();
      mem_ready = e.rdy;
      @(negedge clk);
      check_eq(e.tag, 32'(obs), 32'(e.exp));
      if (retire === 1'b1) n_retire_obs++;
      @(posedge clk);
      #1;
    end
  endtask

  // Build and run the expected cycle schedule of one instruction.
  task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait, input logic bt,
                           input int trap_tail);
    outs_t o;
    bit is_load, is_store, to_wb, legal;
    opcode = op;
    branch_taken = bt;
    is_load  = (op == 7'b0000011);
    is_store = (op == 7'b0100011);
    legal = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1'b1;
    to_wb = 1'b0;

    o = '0; o.mem_req = 1'b1; o.b = 2'd2; o.add = 1'b1;
    for (int i = 0; i < fwait; i++) sched.push_back(mk(1'b0, o, "fetch_wait"));
    o.ir_en = 1'b1; o.pc_en = 1'b1;
    sched.push_back(mk(1'b1, o, "fetch_done"));

    o = '0; o.ab_en = 1'b1; o.aluout_en = 1'b1; o.a = 2'd3; o.b = 2'd1; o.add = 1'b1;
    sched.push_back(mk(1'($urandom_range(0, 1)), o, "decode"));

    o = '0;
    case (op)
      7'b0110011: begin o.a = 2'd1; o.aluout_en = 1'b1; to_wb = 1'b1; end
      7'b0010011: begin o.a = 2'd1; o.b = 2'd1; o.aluout_en = 1'b1; to_wb = 1'b1; end
      7'b0000011, 7'b0100011: begin o.a = 2'd1; o.b = 2'd1; o.add = 1'b1; o.aluout_en = 1'b1; end
      7'b0110111: begin o.a = 2'd2; o.b = 2'd1; o.add = 1'b1; o.aluout_en = 1'b1; to_wb = 1'b1; end
      7'b0010111: begin o.a = 2'd3; o.b = 2'd1; o.add = 1'b1; o.aluout_en = 1'b1; to_wb = 1'b1; end
      7'b1100011: begin o.a = 2'd1; o.pc_src = 2'd1; o.pc_en = bt; o.retire = 1'b1; end
      7'b1101111: begin o.pc_src = 2'd1; o.pc_en = 1'b1; o.rf_we = 1'b1; o.wb = 2'd2; o.retire = 1'b1; end
      7'b1100111: begin
        o.a = 2'd1; o.b = 2'd1; o.add = 1'b1; o.pc_src = 2'd2; o.pc_en = 1'b1;
        o.rf_we = 1'b1; o.wb = 2'd2; o.retire = 1'b1;
      end
      default: begin
`ifndef ILLEGAL_TRAP_EN
        o.retire = 1'b1;
`endif
      end
    endcase
    sched.push_back(mk(1'($urandom_range(0, 1)), o, "exec"));

    if (is_load || is_store) begin
      o = '0; o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = is_store;
      for (int i = 0; i < mwait; i++) sched.push_back(mk(1'b0, o, "mem_wait"));
      o.mdr_en = is_load; o.retire = is_store;
      sched.push_back(mk(1'b1, o, "mem_done"));
      to_wb = is_load;
    end
    if (to_wb) begin
      o = '0; o.rf_we = 1'b1; o.wb = is_load ? 2'd1 : 2'd0; o.retire = 1'b1;
      sched.push_back(mk(1'($urandom_range(0, 1)), o, "wb"));
    end
    o = '0; o.illegal = 1'b1;
    for (int i = 0; i < trap_tail; i++) sched.push_back(mk(1'($urandom_range(0, 1)), o, "trap"));

`ifdef ILLEGAL_TRAP_EN
    if (legal) n_retire_exp++;
`else
    n_retire_exp++;
`endif
    run_sched();
  endtask

  initial begin
    logic [6:0] op;
    int idx;
    rst = 1'b1; opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b1;
    @(negedge clk); check_eq("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk); check_eq("reset_outputs_2", 32'(obs), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Directed cases
    run_instr(7'b0110011, 0, 0, 1'b0, 0);
    run_instr(7'b0000011, 0, 3, 1'b0, 0);
    run_instr(7'b0100011, 0, 0, 1'b0, 0);
    run_instr(7'b1100011, 0, 0, 1'b1, 0);
    run_instr(7'b1100011, 0, 0, 1'b0, 0);
    run_instr(7'b1101111, 2, 0, 1'b0, 0);
    run_instr(7'b1100111, 0, 0, 1'b1, 0);
`ifndef ILLEGAL_TRAP_EN
    run_instr(7'h7F, 0, 0, 1'b0, 0);
`endif

    // Asynchronous reset in the middle of a waiting fetch
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_eq("async_reset_midfetch", 32'(obs), 32'd0);
    @(negedge clk); check_eq("reset_held", 32'(obs), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
`ifdef ILLEGAL_TRAP_EN
      idx = $urandom_range(0, 8);
`else
      idx = $urandom_range(0, 9);
`endif
      op = (idx == 9) ? 7'($urandom_range(0, 127)) : legal_ops[idx];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

`ifdef ILLEGAL_TRAP_EN
    run_instr(7'h7F, 0, 0, 1'b0, 20);
    rst = 1'b1;
    #1 check_eq("trap_cleared_by_reset", 32'(obs), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    run_instr(7'b0110011, 0, 0, 1'b0, 0);
`endif

    check_eq("retire_count", 32'(n_retire_obs), 32'(n_retire_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
